// File: rtl/id_ex_stage.sv
// id_ex_stage: elastic ID/EX pipeline register with a two-entry skid buffer.
// Main entry M drives the execute side; skid entry S absorbs one beat while
// execute back-pressures. When M is empty the stage presents a NOP bubble.
// All state updates on the falling edge of clk.
// Optional feature: define ID_EX_PERF_EN to build the stall/bubble counters;
// without it the counter ports are tied to zero.
module id_ex_stage #(
   parameter int                DATA_W = 32,
   parameter int                REG_W  = 5,
   parameter int                OP_W   = 5,
   parameter logic [OP_W-1:0]   NOP_OP = {OP_W{1'b1}},
   parameter int                CNT_W  = 16
) (
   input  logic                clk,
   input  logic                Reset,
   input  logic                Flush,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [OP_W-1:0]     in_opcode,
   input  logic                in_bsel,
   input  logic [REG_W-1:0]    in_rd,
   input  logic [DATA_W-1:0]   in_rvalue1,
   input  logic [DATA_W-1:0]   in_rvalue2,
   input  logic [DATA_W-1:0]   in_imm,
   input  logic                in_memrd,
   input  logic                in_memwr,
   input  logic                in_regwrite,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [OP_W-1:0]     out_opcode,
   output logic                out_bsel,
   output logic [REG_W-1:0]    out_rd,
   output logic [DATA_W-1:0]   out_rvalue1,
   output logic [DATA_W-1:0]   out_rvalue2,
   output logic [DATA_W-1:0]   out_imm,
   output logic                out_memrd,
   output logic                out_memwr,
   output logic                out_regwrite,
   output logic [CNT_W-1:0]    stall_cnt,
   output logic [CNT_W-1:0]    bubble_cnt
);

   typedef struct packed {
      logic [OP_W-1:0]   opcode;
      logic              bsel;
      logic [REG_W-1:0]  rd;
      logic [DATA_W-1:0] rvalue1;
      logic [DATA_W-1:0] rvalue2;
      logic [DATA_W-1:0] imm;
      logic              memrd;
      logic              memwr;
      logic              regwrite;
   } entry_t;

   // Contents M takes on reset: NOP opcode, everything else zero.
   function automatic entry_t reset_entry();
      entry_t e;
      e        = '0;
      e.opcode = NOP_OP;
      return e;
   endfunction

   entry_t m_r;
   entry_t s_r;
   logic   m_valid_r;
   logic   s_valid_r;
   entry_t in_entry_s;
   logic   accept_s;
   logic   issue_s;

   assign in_entry_s = '{opcode:   in_opcode,
                         bsel:     in_bsel,
                         rd:       in_rd,
                         rvalue1:  in_rvalue1,
                         rvalue2:  in_rvalue2,
                         imm:      in_imm,
                         memrd:    in_memrd,
                         memwr:    in_memwr,
                         regwrite: in_regwrite};

   // in_ready depends only on held state and Reset, never on out_ready.
   assign in_ready = ~s_valid_r & ~Reset;
   assign accept_s = in_valid & in_ready;
   assign issue_s  = m_valid_r & out_ready;

   // Entry movement: reset, then flush, then FIFO advance of S->M or input->M/S.
   always_ff @(negedge clk) begin
      if (Reset) begin
         m_valid_r <= 1'b0;
         s_valid_r <= 1'b0;
         m_r       <= reset_entry();
         s_r       <= reset_entry();
      end else if (Flush) begin
         m_valid_r <= 1'b0;
         s_valid_r <= 1'b0;
      end else if (!m_valid_r || issue_s) begin
         if (s_valid_r) begin
            m_r       <= s_r;
            m_valid_r <= 1'b1;
            s_valid_r <= 1'b0;
         end else if (accept_s) begin
            m_r       <= in_entry_s;
            m_valid_r <= 1'b1;
         end else begin
            m_valid_r <= 1'b0;
         end
      end else if (accept_s) begin
         s_r       <= in_entry_s;
         s_valid_r <= 1'b1;
      end else begin
         s_valid_r <= s_valid_r;
      end
   end

   // Execute-side view; side effects and opcode are masked while M is empty.
   assign out_valid    = m_valid_r;
   assign out_opcode   = m_valid_r ? m_r.opcode : NOP_OP;
   assign out_bsel     = m_r.bsel;
   assign out_rd       = m_r.rd;
   assign out_rvalue1  = m_r.rvalue1;
   assign out_rvalue2  = m_r.rvalue2;
   assign out_imm      = m_r.imm;
   assign out_memrd    = m_valid_r & m_r.memrd;
   assign out_memwr    = m_valid_r & m_r.memwr;
   assign out_regwrite = m_valid_r & m_r.regwrite;

`ifdef ID_EX_PERF_EN
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] stall_cnt_r;
   logic [CNT_W-1:0] bubble_cnt_r;

   // Saturating stall/bubble counters; only Reset clears them.
   always_ff @(negedge clk) begin
      if (Reset) begin
         stall_cnt_r  <= {CNT_W{1'b0}};
         bubble_cnt_r <= {CNT_W{1'b0}};
      end else begin
         if (m_valid_r && !out_ready && !(&stall_cnt_r)) begin
            stall_cnt_r <= stall_cnt_r + CNT_ONE;
         end else begin
            stall_cnt_r <= stall_cnt_r;
         end
         if (!m_valid_r && out_ready && !(&bubble_cnt_r)) begin
            bubble_cnt_r <= bubble_cnt_r + CNT_ONE;
         end else begin
            bubble_cnt_r <= bubble_cnt_r;
         end
      end
   end

   assign stall_cnt  = stall_cnt_r;
   assign bubble_cnt = bubble_cnt_r;
`else
   assign stall_cnt  = {CNT_W{1'b0}};
   assign bubble_cnt = {CNT_W{1'b0}};
`endif

endmodule
